// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared control encodings for the HI/LO multiply/divide unit:
//   operation codes presented on the op port and the controller state
//   encoding. Both the controller and its testbench import this package.
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  // Operation codes on the 3-bit op port. Codes 6 and 7 are reserved and
  // are ignored by the controller.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Number of radix-2 iterations for a 32-bit operand.
  localparam int unsigned MD_STEPS = 32;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // True for the operations whose operands are two's-complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//   Purely combinational single radix-2 iteration on the 2*WIDTH-bit working
//   register.
//   Multiply (shift-add): working register holds {partial, multiplier}.
//     If the multiplier LSB is set the multiplicand is added to the upper
//     half, then the whole register (with the carry) shifts right by one.
//   Divide (restoring): working register holds {remainder, dividend/quotient}.
//     The register shifts left by one; if the shifted-up remainder is at
//     least the divisor it is reduced and a 1 quotient bit enters the LSB.
//
// Ports
//   w_i        in  2*WIDTH  current working register
//   operand_i  in  WIDTH    multiplicand (multiply) or divisor (divide)
//   div_mode_i in  1        0 = multiply step, 1 = divide step
//   w_o        out 2*WIDTH  next working register
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] w_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] w_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    // Multiply: keep the carry-out so the right shift does not lose it.
    mul_sum  = {1'b0, w_i[2*WIDTH-1:WIDTH]}
             + (w_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});

    // Divide: remainder after the left shift needs one extra bit.
    div_part = w_i[2*WIDTH-1:WIDTH-1];
    div_fits = (div_part >= {1'b0, operand_i});
    // Only used when div_fits, in which case the result fits in WIDTH bits.
    div_rem  = div_part[WIDTH-1:0] - operand_i;

    w_o = w_i;
    if (div_mode_i) begin
      if (div_fits) begin
        w_o = {div_rem, w_i[WIDTH-2:0], 1'b1};
      end else begin
        w_o = {div_part[WIDTH-1:0], w_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_o = {mul_sum, w_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative HI/LO multiply/divide controller. Signed operations run on
//   operand magnitudes; the sign is restored in a final fix-up cycle.
//   A MULT/DIV started in cycle 0 keeps busy high in cycles 1..33 and
//   commits HI/LO with a done pulse in cycle 34.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset, overrides everything
//   start   in   1      launch op (only honoured in IDLE)
//   op      in   3      operation code (see muldiv_ctrl_pkg)
//   A       in   WIDTH  rs operand: multiplicand / dividend / MTHI,MTLO data
//   B       in   WIDTH  rt operand: multiplier / divisor
//   cancel  in   1      flush: aborts an in-flight op, blocks a launch
//   busy    out  1      op in flight (registered)
//   done    out  1      one-cycle pulse on HI/LO commit (or divide by zero)
//   dz      out  1      one-cycle divide-by-zero pulse, with done
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; MTHI/MTLO and divide-by-zero finish here
// ST_RUN  | 32 radix-2 iterations on the working register
// ST_FIX  | sign correction, HI/LO write, done pulse
// ---------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] w_step;
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .w_i       (w_q),
    .operand_i (opnd_q),
    .div_mode_i(div_q),
    .w_o       (w_step)
  );

  // Operand magnitudes. The most negative value negates to itself, which
  // is exactly its unsigned magnitude, so 0x80000000 needs no special case.
  always_comb begin
    op_signed = md_is_signed(op);
    a_abs     = (op_signed && A[WIDTH-1]) ? -A : A;
    b_abs     = (op_signed && B[WIDTH-1]) ? -B : B;
  end

  // Sign fix-up of the finished working register.
  always_comb begin
    prod_fix = neg_res_q ? -w_q : w_q;
    quo_fix  = neg_res_q ? -w_q[WIDTH-1:0] : w_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -w_q[2*WIDTH-1:WIDTH] : w_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // cancel beats a same-cycle start.
        if (start && !cancel) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_d   = ST_RUN;
              cnt_d     = 5'd0;
              div_d     = 1'b0;
              w_d       = {{WIDTH{1'b0}}, b_abs};
              opnd_d    = a_abs;
              neg_res_d = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              if (B == '0) begin
                // Divide by zero completes immediately without touching HI/LO.
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                state_d   = ST_RUN;
                cnt_d     = 5'd0;
                div_d     = 1'b1;
                w_d       = {{WIDTH{1'b0}}, a_abs};
                opnd_d    = b_abs;
                neg_res_d = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                // Remainder follows the dividend's sign.
                neg_rem_d = op_signed && A[WIDTH-1];
              end
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          w_d   = w_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(MD_STEPS - 1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      w_q       <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  // Reference copy of HI/LO.
  logic [31:0] mhi;
  logic [31:0] mlo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op_s),
    .A     (a_s),
    .B     (b_s),
    .cancel(cancel),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          ecyc;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Architectural result of one op, from plain integer arithmetic.
  function automatic void model(input logic [2:0] mop, input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
      end
      3'd3: if (b != 0) begin l = a / b; h = a % b; end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Launch op in cycle 0 and wait for done; cyc is the done cycle (-1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic dz_seen, output logic busy_seen);
    start = 1'b1; op_s = o; a_s = a; b_s = b;
    tick();
    start = 1'b0;
    cyc = 1;
    busy_seen = busy;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      busy_seen = busy_seen | busy;
    end
    if (!done) cyc = -1;
    dz_seen = dz;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op_s = o; a_s = a; b_s = 32'h0;
    tick();
    start = 1'b0;
    model(o, a, 32'h0, mhi, mlo);
    chk("mt_hi", hi, mhi);
    chk("mt_lo", lo, mlo);
    chk("mt_busy", busy, 0);
    chk("mt_done", done, 0);
  endtask

  task automatic quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen = seen | done | dz;
      tick();
    end
  endtask

  initial begin
    int          cyc;
    logic        dzs;
    logic        bsy;
    logic        seen;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        is_dz;

    rst = 1'b1; start = 1'b0; op_s = 3'd0; a_s = 32'h0; b_s = 32'h0; cancel = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;
    mhi = 32'h0; mlo = 32'h0;

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);

    vecs[0] = '{MD_DIVU,  32'h7,        32'h0,        32'h11,       32'h22,       1'b1, 1};
    vecs[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
    vecs[2] = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34};
    vecs[5] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 34};
    vecs[7] = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 34};
    vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, 34};

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dzs, bsy);
      chk($sformatf("vec%0d_cyc", i), cyc, vecs[i].ecyc);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
      chk($sformatf("vec%0d_dz", i), dzs, vecs[i].edz);
      chk($sformatf("vec%0d_busy", i), bsy, vecs[i].ecyc != 1);
      tick();
      chk($sformatf("vec%0d_pulse", i), done, 0);
      mhi = vecs[i].ehi; mlo = vecs[i].elo;
    end

    // In-flight start ignored, cancel during RUN.
    start = 1'b1; op_s = MD_MULT; a_s = 32'h1234; b_s = 32'h5678;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 11; c++) begin
      seen = seen | done;
      if (c == 5) begin
        start = 1'b1; op_s = MD_DIVU; a_s = 32'd9; b_s = 32'd3;
      end else begin
        start = 1'b0;
      end
      cancel = (c == 10);
      tick();
    end
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_hi", hi, mhi);
    chk("cancel_lo", lo, mlo);
    quiet(40, dzs);
    chk("cancel_nodone", seen | dzs, 0);
    run_op(MD_DIVU, 32'd9, 32'd3, cyc, dzs, bsy);
    chk("after_cancel_cyc", cyc, 34);
    chk("after_cancel_lo", lo, 3);
    chk("after_cancel_hi", hi, 0);
    mhi = 32'h0; mlo = 32'h3;
    tick();

    // Cancel landing on the FIX cycle.
    start = 1'b1; op_s = MD_DIVU; a_s = 32'd100; b_s = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c < 33; c++) tick();
    chk("fix_busy", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("fix_cancel_done", done, 0);
    chk("fix_cancel_busy", busy, 0);
    chk("fix_cancel_hi", hi, mhi);
    chk("fix_cancel_lo", lo, mlo);

    // cancel beats start in IDLE.
    start = 1'b1; cancel = 1'b1; op_s = MD_MTHI; a_s = 32'hDEAD;
    tick();
    chk("idle_cancel_mthi", hi, mhi);
    op_s = MD_MULT; a_s = 32'h3; b_s = 32'h3;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", busy, 0);
    quiet(40, seen);
    chk("idle_cancel_nodone", seen, 0);

    // Reserved codes.
    for (int r = 6; r < 8; r++) begin
      start = 1'b1; op_s = 3'(r); a_s = 32'hAAAA5555; b_s = 32'h3;
      tick();
      start = 1'b0;
      chk("rsvd_busy", busy, 0);
      quiet(36, seen);
      chk("rsvd_nodone", seen, 0);
      chk("rsvd_hi", hi, mhi);
      chk("rsvd_lo", lo, mlo);
    end

    // Randomised ops against the reference model.
    for (int n = 0; n < 30; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      if (ro <= 3'd3) begin
        is_dz = (ro >= 3'd2) && (rb == 32'h0);
        ehi = mhi; elo = mlo;
        model(ro, ra, rb, ehi, elo);
        run_op(ro, ra, rb, cyc, dzs, bsy);
        chk($sformatf("rnd%0d_cyc", n), cyc, is_dz ? 1 : 34);
        chk($sformatf("rnd%0d_dz", n), dzs, is_dz);
        chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, ro, ra, rb), hi, ehi);
        chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, ro, ra, rb), lo, elo);
        mhi = ehi; mlo = elo;
        tick();
      end else if (ro <= 3'd5) begin
        mt(ro, ra);
      end else begin
        start = 1'b1; op_s = ro; a_s = ra; b_s = rb;
        tick();
        start = 1'b0;
        chk("rnd_rsvd_busy", busy, 0);
        chk("rnd_rsvd_done", done, 0);
        chk("rnd_rsvd_hi", hi, mhi);
      end
    end

    // Reset in the middle of a divide.
    start = 1'b1; op_s = MD_DIV; a_s = 32'hFFFFFFF9; b_s = 32'h2;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1; cancel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    chk("rstmid_done", done, 0);
    rst = 1'b0;
    quiet(40, seen);
    chk("rstmid_nodone", seen, 0);
    chk("rstmid_busy_late", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
